// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//
// Plays a fixed wake-up melody on the 12-note piezo tone block. The melody is
// held in a small internal ROM of {code, dur} entries. Each entry lasts
// dur*BEAT_CNT clock cycles. The last GAP_CNT cycles of each entry are silent,
// which separates consecutive notes.
//
// Ports:
//   clk        in   1   system clock (1 MHz nominal)
//   rst        in   1   asynchronous, active-low reset
//   start      in   1   one-cycle request to begin the melody from entry 0
//   stop       in   1   one-cycle request to abort playback (wins over start)
//   playSound  out 13   one-hot note select (bit n = tone n); zero = silent
//   busy       out  1   high while a note or gap is being played
//   done       out  1   one-cycle pulse when the melody ends normally
//   note_idx   out  4   current ROM index (debug)
//
// Build option:
//   MELODY_SEQ_LOOP_EN - when defined, the melody restarts at entry 0 instead
//                        of finishing. Only stop or reset ends playback.
// -----------------------------------------------------------------------------
module melody_sequencer #(
    parameter int BEAT_CNT = 250000,  // cycles per beat, must exceed GAP_CNT
    parameter int GAP_CNT  = 20000,   // silent cycles at the end of each entry
    parameter int MEL_LEN  = 16       // ROM entries
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [12:0] playSound,
    output logic        busy,
    output logic        done,
    output logic [3:0]  note_idx
);

    localparam logic [3:0] CODE_END = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Melody ROM: twelve ascending notes, a two-beat rest, a four-beat top note,
    // then end markers.
    // -------------------------------------------------------------------------
    function automatic logic [3:0] rom_code(input logic [3:0] a);
        if (a < 4'd12)       rom_code = a + 4'd1;
        else if (a == 4'd12) rom_code = 4'd0;
        else if (a == 4'd13) rom_code = 4'd12;
        else                 rom_code = CODE_END;
    endfunction

    function automatic logic [3:0] rom_dur(input logic [3:0] a);
        if (a < 4'd12)       rom_dur = 4'd1;
        else if (a == 4'd12) rom_dur = 4'd2;
        else if (a == 4'd13) rom_dur = 4'd4;
        else                 rom_dur = 4'd0;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [19:0] cnt_q, cnt_d;
    logic [12:0] play_q, play_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Entry length is computed at 32 bits so dur*BEAT_CNT never truncates; the
    // 20-bit counter is zero-extended for the comparisons.
    logic [3:0]  cur_dur;
    logic [3:0]  dur_eff;
    logic [31:0] entry_len;
    logic [31:0] play_len;
    logic [31:0] cnt_ext;
    logic [3:0]  idx_nx;
    logic        last_entry;
    logic [3:0]  play_code;
    logic [12:0] note_oh;

    assign cur_dur    = rom_dur(idx_q);
    assign dur_eff    = (cur_dur == 4'd0) ? 4'd1 : cur_dur;
    assign entry_len  = 32'(dur_eff) * 32'(BEAT_CNT);
    assign play_len   = entry_len - 32'(GAP_CNT);
    assign cnt_ext    = {12'd0, cnt_q};
    assign idx_nx     = idx_q + 4'd1;
    assign last_entry = (idx_q == 4'(MEL_LEN - 1)) || (rom_code(idx_nx) == CODE_END);

    // One-hot decode of the entry that will be playing next cycle. Only codes
    // 1..12 light a bit, so rests, end markers and bit 0 stay silent and the
    // bus can never be multi-hot.
    assign play_code  = rom_code(idx_d);
    assign note_oh[0] = 1'b0;
    generate
        for (genvar gi = 1; gi <= 12; gi++) begin : g_note_dec
            assign note_oh[gi] = (play_code == 4'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    idx_d = 4'd0;
                    cnt_d = 20'd0;
                    if (rom_code(4'd0) == CODE_END) begin
`ifdef MELODY_SEQ_LOOP_EN
                        state_d = S_IDLE;  // nothing to loop over
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_PLAY;
                    end
                end
            end

            S_PLAY: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                    if (cnt_ext == play_len - 32'd1) begin
                        state_d = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = 20'd0;
                end else if (cnt_ext == entry_len - 32'd1) begin
                    cnt_d = 20'd0;
                    if (last_entry) begin
`ifdef MELODY_SEQ_LOOP_EN
                        idx_d   = 4'd0;
                        state_d = S_PLAY;
`else
                        // Advance onto the end marker; on the final index
                        // there is nothing to advance to, so it holds.
                        if (idx_q != 4'(MEL_LEN - 1)) begin
                            idx_d = idx_nx;
                        end
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_nx;
                        state_d = S_PLAY;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state so that the registered
        // copies line up with the state they describe.
        play_d = (state_d == S_PLAY) ? note_oh : 13'd0;
        busy_d = (state_d == S_PLAY) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 20'd0;
            play_q  <= 13'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            play_q  <= play_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign playSound = play_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign note_idx  = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
//
// Bench for melody_sequencer with BEAT_CNT=10, GAP_CNT=2. The reference model
// expands the melody table into a per-cycle schedule of expected outputs and
// tracks playback as a position in that schedule.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 2;
`ifdef MELODY_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [12:0] playSound;
    logic        busy;
    logic        done;
    logic [3:0]  note_idx;

    melody_sequencer #(
        .BEAT_CNT(BEAT),
        .GAP_CNT (GAP),
        .MEL_LEN (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .playSound(playSound),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // ---------------- reference model ----------------
    int m_code[16];
    int m_dur[16];
    int sched_ps[$];
    int sched_idx[$];
    int total;

    bit m_active;
    bit m_in_done;
    int m_t;
    bit m_idx_ok;
    int m_idx;

    function automatic void build_schedule();
        for (int i = 0; i < 16; i++) begin
            if (i < 12) begin m_code[i] = i + 1; m_dur[i] = 1; end
            else if (i == 12) begin m_code[i] = 0; m_dur[i] = 2; end
            else if (i == 13) begin m_code[i] = 12; m_dur[i] = 4; end
            else begin m_code[i] = 13; m_dur[i] = 0; end
        end
        for (int e = 0; e < 16; e++) begin
            int d;
            int len;
            if (m_code[e] == 13) break;
            d   = (m_dur[e] == 0) ? 1 : m_dur[e];
            len = d * BEAT;
            for (int k = 0; k < len; k++) begin
                if (k < len - GAP && m_code[e] >= 1 && m_code[e] <= 12)
                    sched_ps.push_back(1 << m_code[e]);
                else
                    sched_ps.push_back(0);
                sched_idx.push_back(e);
            end
        end
        total = sched_ps.size();
    endfunction

    function automatic void model_reset();
        m_active  = 1'b0;
        m_in_done = 1'b0;
        m_t       = 0;
        m_idx_ok  = 1'b1;
        m_idx     = 0;
    endfunction

    // Advance the model across one clock edge with the given requests.
    function automatic void model_update(bit s, bit p);
        if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (m_active) begin
            if (p) begin
                m_active = 1'b0;
                m_idx_ok = 1'b0;
            end else begin
                m_t++;
                if (m_t >= total) begin
                    if (LOOP) m_t = 0;
                    else begin
                        m_active  = 1'b0;
                        m_in_done = 1'b1;
                        m_idx_ok  = 1'b0;
                    end
                end
            end
        end else if (s && !p) begin
            m_active = 1'b1;
            m_t      = 0;
        end
        if (m_active) begin
            m_idx    = sched_idx[m_t];
            m_idx_ok = 1'b1;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive requests, sample 1 time unit after the edge, compare
    // everything against the model.
    task automatic step(input bit s, input bit p);
        logic [12:0] eps;
        bit bad;
        start = s;
        stop  = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        model_update(s, p);
        eps = m_active ? 13'(sched_ps[m_t]) : 13'h0;
        bad = (playSound !== eps) || (busy !== m_active) || (done !== m_in_done)
              || (m_idx_ok && (note_idx !== 4'(m_idx)))
              || ($countones(playSound) > 1) || (playSound[0] !== 1'b0);
        vec_cnt++;
        if (bad) begin
            err_cnt++;
            $display("FAIL model t=%0t: got ps=%h busy=%b done=%b idx=%0d, expected ps=%h busy=%b done=%b idx=%0d",
                     $time, playSound, busy, done, note_idx, eps, m_active, m_in_done, m_idx);
        end
        if (s || p)
            $display("txn t=%0t start=%0d stop=%0d -> ps=%h busy=%b done=%b idx=%0d",
                     $time, s, p, playSound, busy, done, note_idx);
    endtask

    // Called at posedge+1: asserts reset mid-cycle, checks the asynchronous
    // clear, then releases it away from the edge.
    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        check("rst_playSound", int'(playSound), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_note_idx", int'(note_idx), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("txn t=%0t reset released", $time);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit          s;
        bit          p;
        logic [12:0] ps;
        bit          b;
        bit          d;
        bit          ic;
        logic [3:0]  idx;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mkv(bit s, bit p, logic [12:0] ps, bit b, bit d, bit ic, logic [3:0] idx);
        vec_t v;
        v.s = s; v.p = p; v.ps = ps; v.b = b; v.d = d; v.ic = ic; v.idx = idx;
        return v;
    endfunction

    initial begin
        build_schedule();
        model_reset();

        // start+stop together, stop alone, start, start-while-busy, first gap,
        // second note, stop mid-note, stop in idle, replay.
        tbl[0]  = mkv(1, 1, 13'h000, 0, 0, 1, 4'd0);
        tbl[1]  = mkv(0, 1, 13'h000, 0, 0, 1, 4'd0);
        tbl[2]  = mkv(1, 0, 13'h002, 1, 0, 1, 4'd0);
        tbl[3]  = mkv(1, 0, 13'h002, 1, 0, 1, 4'd0);
        tbl[4]  = mkv(0, 0, 13'h002, 1, 0, 1, 4'd0);
        tbl[5]  = mkv(0, 0, 13'h002, 1, 0, 1, 4'd0);
        tbl[6]  = mkv(0, 0, 13'h002, 1, 0, 1, 4'd0);
        tbl[7]  = mkv(0, 0, 13'h002, 1, 0, 1, 4'd0);
        tbl[8]  = mkv(0, 0, 13'h002, 1, 0, 1, 4'd0);
        tbl[9]  = mkv(0, 0, 13'h002, 1, 0, 1, 4'd0);
        tbl[10] = mkv(0, 0, 13'h000, 1, 0, 1, 4'd0);
        tbl[11] = mkv(0, 0, 13'h000, 1, 0, 1, 4'd0);
        tbl[12] = mkv(0, 0, 13'h004, 1, 0, 1, 4'd1);
        tbl[13] = mkv(0, 1, 13'h000, 0, 0, 0, 4'd0);
        tbl[14] = mkv(0, 1, 13'h000, 0, 0, 0, 4'd0);
        tbl[15] = mkv(1, 0, 13'h002, 1, 0, 1, 4'd0);

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            start = tbl[i].s;
            stop  = tbl[i].p;
            @(posedge clk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            model_update(tbl[i].s, tbl[i].p);
            vec_cnt++;
            if (playSound !== tbl[i].ps || busy !== tbl[i].b || done !== tbl[i].d
                || (tbl[i].ic && note_idx !== tbl[i].idx)) begin
                err_cnt++;
                $display("FAIL vec%0d: got ps=%h busy=%b done=%b idx=%0d, expected ps=%h busy=%b done=%b idx=%0d",
                         i, playSound, busy, done, note_idx, tbl[i].ps, tbl[i].b, tbl[i].d, tbl[i].idx);
            end
            $display("vec %0d start=%0d stop=%0d -> ps=%h busy=%b done=%b idx=%0d",
                     i, tbl[i].s, tbl[i].p, playSound, busy, done, note_idx);
        end
        step(0, 1);

        // Full melody with a start request at cycle 50 that must be ignored.
        step(1, 0);
        for (int c = 2; c <= 200; c++) begin
            step(c == 51, 0);
            if (c == 8)   check("c8_ps", int'(playSound), 'h002);
            if (c == 9)   check("c9_ps", int'(playSound), 'h000);
            if (c == 10)  check("c10_ps", int'(playSound), 'h000);
            if (c == 11)  check("c11_ps", int'(playSound), 'h004);
            if (c >= 121 && c <= 140) check("rest_ps", int'(playSound), 'h000);
            if (c == 121) check("c121_idx", int'(note_idx), 12);
            if (c == 141) check("c141_ps", int'(playSound), 'h1000);
            if (c == 178) check("c178_ps", int'(playSound), 'h1000);
            if (c == 179) check("c179_ps", int'(playSound), 'h000);
            if (c == 180) check("c180_done", int'(done), 0);
`ifdef MELODY_SEQ_LOOP_EN
            if (c == 181) check("c181_loop_ps", int'(playSound), 'h002);
            if (c == 181) check("c181_loop_busy", int'(busy), 1);
            check("loop_no_done", int'(done), 0);
`else
            if (c == 181) check("c181_done", int'(done), 1);
            if (c >= 181) check("end_busy", int'(busy), 0);
            if (c == 182) check("c182_done", int'(done), 0);
`endif
        end
        step(0, 1);

        // Stop during the first gap: no done pulse, then a clean replay.
        step(1, 0);
        for (int c = 2; c <= 9; c++) step(0, 0);
        step(0, 1);
        check("gapstop_busy", int'(busy), 0);
        check("gapstop_ps", int'(playSound), 0);
        for (int c = 0; c < 20; c++) begin
            step(0, 0);
            check("gapstop_no_done", int'(done), 0);
        end
        step(1, 0);
        check("replay_ps", int'(playSound), 'h002);
        check("replay_idx", int'(note_idx), 0);
        step(0, 1);

        // Reset while entry 3 is sounding.
        step(1, 0);
        for (int c = 2; c <= 35; c++) step(0, 0);
        check("pre_rst_idx", int'(note_idx), 3);
        check("pre_rst_ps", int'(playSound), 'h010);
        do_reset();
        for (int c = 0; c < 5; c++) step(0, 0);
        check("post_rst_busy", int'(busy), 0);

`ifdef MELODY_SEQ_LOOP_EN
        // Three full loops without a done pulse, then stop.
        step(1, 0);
        for (int c = 2; c <= 3 * 180 + 5; c++) begin
            step(0, 0);
            check("loop3_no_done", int'(done), 0);
        end
        step(0, 1);
        check("loop_stop_busy", int'(busy), 0);
`endif

        // Randomized requests against the model.
        for (int c = 0; c < 3000; c++) begin
            bit s;
            bit p;
            s = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 199) == 0);
            step(s, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a fixed wake-up melody on the 12-note piezo tone block.
- Drives that block's 13-bit one-hot note-select bus (bit n enables tone n, bits 1..12 used) over time.
- Melody lives in an internal ROM of note/duration entries. A beat counter sets the tempo, and a short silent gap separates consecutive notes.
- Sits between the alarm/nap control logic (start/stop) and the piezo tone block.

Parameters:
- BEAT_CNT, 250000, clk cycles per beat (0.25 s at 1 MHz clk); must be > GAP_CNT
- GAP_CNT, 20000, silent cycles at the end of each note entry; must be ≥ 1
- MEL_LEN, 16, number of ROM entries (index width 4)

Ports:
- clk  in  1  system clock (1 MHz)
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin the melody from entry 0
- stop  in  1  one-cycle request to abort playback
- playSound  out  13  one-hot note select to the tone block; all-zero = silent
- busy  out  1  high while in PLAY or GAP
- done  out  1  one-cycle pulse when the melody ends normally
- note_idx  out  4  current ROM index (debug)

Behaviour:
- Reset (rst=0, async): state IDLE; playSound=0, busy=0, done=0, note_idx=0; all counters cleared. Applies immediately, including mid-note.
- ROM entry format: code[3:0], dur[3:0].
  - code 1..12: note, drives playSound[code].
  - code 0, 14, 15: rest, all-zero output.
  - code 13: end marker.
  - dur 0 is treated as 1.
- ROM contents:
  - idx 0..11: code idx+1, dur 1
  - idx 12: code 0, dur 2
  - idx 13: code 12, dur 4
  - idx 14, 15: code 13
- States: IDLE, PLAY, GAP, DONE.
- IDLE:
  - start=1 → PLAY, idx=0, cycle counter cleared.
  - playSound asserted on the cycle after start is sampled (1-cycle latency).
  - If entry 0 is the end marker, go directly to DONE.
- Entry length: every entry occupies exactly L = dur*BEAT_CNT cycles.
  - PLAY lasts L−GAP_CNT cycles with playSound = one-hot(code), or 0 for a rest.
  - GAP lasts GAP_CNT cycles with playSound=0.
- End of GAP:
  - Advance idx.
  - Next code 13 → DONE.
  - idx was MEL_LEN−1 → DONE; no wrap.
  - Otherwise → PLAY of the next entry. No extra idle cycle between entries.
- DONE: exactly one cycle, done=1, playSound=0, busy=0, then IDLE; note_idx holds its last value until the next start.
- stop=1 in PLAY or GAP:
  - Next cycle: IDLE, playSound=0, busy=0.
  - No done pulse.
- Simultaneous events:
  - stop and start together: stop wins.
  - start while busy: ignored; no restart.
  - stop in IDLE: no effect.
- Outputs are registered. playSound is guaranteed one-hot or zero, never multi-hot.
- Counters: cycle counter is 20 bits, compared against dur*BEAT_CNT computed at full width with no truncation.

Optional Feature:
- Macro: MELODY_SEQ_LOOP_EN.
- Defined: reaching the end marker or the last index does not enter DONE. The block instead restarts at idx 0 in PLAY on the next cycle; busy stays 1 and done never pulses. Only stop or reset ends playback.
- Undefined: single-shot behaviour as above.

Test Plan (BEAT_CNT=10, GAP_CNT=2):
- Reset mid-note: rst low during PLAY of idx 3 → playSound=0, busy=0, note_idx=0 in the same cycle; stays in IDLE after rst releases.
- Full melody (start at cycle 0):
  - playSound=13'h002 for cycles 1–8; 0 for cycles 9–10; 13'h004 from cycle 11.
  - idx 12 rest silent for cycles 121–140; playSound=13'h1000 for cycles 141–178.
  - done=1 at cycle 181 only; busy=0 from cycle 181.
- Stop in GAP: stop at cycle 9 → cycle 10 IDLE, playSound=0, no done pulse; later start replays from idx 0.
- start and stop together in IDLE → remains IDLE. start while busy at cycle 50 → timing identical to an undisturbed run.
- One-hot check: every cycle of a full run, popcount(playSound) ≤ 1 and playSound[0]=0.
- Loop build (MELODY_SEQ_LOOP_EN defined): after idx 13 completes, playSound=13'h002 again at cycle 181; done never asserts over 3 loops; stop ends playback.
